// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// Latency: grant registered 1 cycle after cyc; request and response paths are combinational while granted.
// Backpressure: grant held for the whole cyc; unanswered strobes are aborted with err after TIMEOUT cycles.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
    output logic [DW-1:0]                 wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [NUM_MASTERS-1:0]        wbm_rty_o,
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    output logic [2:0]                    wbs_cti_o,
    output logic [1:0]                    wbs_bte_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    input  logic                          wbs_rty_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_gidx, w_gidx_nxt;
    logic [IW-1:0]          r_last, w_last_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [IW-1:0]          w_win;
    logic                   w_busy, w_resp;
    logic                   w_cyc_g, w_stb_g, w_we_g;
    logic [AW-1:0]          w_adr_g;
    logic [DW-1:0]          w_dat_g;
    logic [SW-1:0]          w_sel_g;
    logic [2:0]             w_cti_g;
    logic [1:0]             w_bte_g;

    // First requester after 'last' in rotating order; scanned backwards so the nearest one wins.
    function automatic logic [IW-1:0] f_rr_pick(input logic [IW-1:0] last,
                                                input logic [NUM_MASTERS-1:0] req);
        logic [IW-1:0] pick;
        pick = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % NUM_MASTERS;
            if (req[IW'(idx)]) pick = IW'(idx);
        end
        return pick;
    endfunction

    assign w_win  = f_rr_pick(r_last, wbm_cyc_i);
    assign w_busy = (r_state == S_BUSY);
    assign w_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    always_comb begin
        w_cyc_g = 1'b0;
        w_stb_g = 1'b0;
        w_we_g  = 1'b0;
        w_adr_g = '0;
        w_dat_g = '0;
        w_sel_g = '0;
        w_cti_g = '0;
        w_bte_g = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_gidx == IW'(i)) begin
                w_cyc_g = wbm_cyc_i[i];
                w_stb_g = wbm_stb_i[i];
                w_we_g  = wbm_we_i[i];
                w_adr_g = wbm_adr_i[i*AW +: AW];
                w_dat_g = wbm_dat_i[i*DW +: DW];
                w_sel_g = wbm_sel_i[i*SW +: SW];
                w_cti_g = wbm_cti_i[i*3 +: 3];
                w_bte_g = wbm_bte_i[i*2 +: 2];
            end
        end
    end

    assign wbs_cyc_o = w_busy & w_cyc_g;
    assign wbs_stb_o = w_busy & w_cyc_g & w_stb_g;
    assign wbs_we_o  = w_busy & w_we_g;
    assign wbs_adr_o = w_busy ? w_adr_g : '0;
    assign wbs_dat_o = w_busy ? w_dat_g : '0;
    assign wbs_sel_o = w_busy ? w_sel_g : '0;
    assign wbs_cti_o = w_busy ? w_cti_g : '0;
    assign wbs_bte_o = w_busy ? w_bte_g : '0;

    // Responses are suppressed while reset is applied so an interrupted access never completes.
    assign wbm_ack_o = (w_busy && wbs_ack_i && !wb_rst_i) ? r_grant : '0;
    assign wbm_rty_o = (w_busy && wbs_rty_i && !wb_rst_i) ? r_grant : '0;
    assign wbm_err_o = (((w_busy && wbs_err_i) || (r_state == S_ABORT)) && !wb_rst_i) ? r_grant : '0;
    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = r_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (|wbm_cyc_i) begin
                    w_gidx_nxt  = w_win;
                    w_grant_nxt = NUM_MASTERS'(1) << w_win;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!w_cyc_g) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_gidx;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (wbs_stb_o && !w_resp) begin
                    if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_state_nxt = S_ABORT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            S_ABORT: begin
                w_cnt_nxt = '0;
                if (w_cyc_g) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = r_gidx;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_gidx  <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule
